// File: rtl/bp_pkg.sv
// Shared types and constants for the branch-predictor update path.
package bp_pkg;

    localparam int BP_PC_W = 32;

    typedef struct packed {
        logic [BP_PC_W-1:0] pc;
        logic               br_en;
    } bp_upd_t;

endpackage

// File: rtl/bp_upd_fifo.sv
// Small in-order FIFO holding resolved branch updates until the predictor port is free.
import bp_pkg::*;

module bp_upd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enq,
    input  bp_upd_t                  enq_data,
    input  logic                     deq,
    output bp_upd_t                  head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    bp_upd_t         mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   cnt;
    logic            enq_ok;
    logic            deq_ok;

    assign full      = (cnt == CW'(DEPTH));
    assign empty     = (cnt == '0);
    assign enq_ok    = enq && !full;
    assign deq_ok    = deq && !empty;
    assign head_data = mem[head];
    assign count     = cnt;

    // Storage is not reset; stale entries are unreachable once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (enq_ok) begin
            mem[tail] <= enq_data;
        end
    end

    // Pointer and occupancy bookkeeping; reset discards everything queued.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (enq_ok) begin
                tail <= tail + 1'b1;
            end
            if (deq_ok) begin
                head <= head + 1'b1;
            end
            cnt <= cnt + CW'(enq_ok) - CW'(deq_ok);
        end
    end

endmodule

// File: rtl/bp_update_arbiter.sv
// Shares the global predictor port between fetch lookups and queued resolve updates.
import bp_pkg::*;

module bp_update_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     lookup_req,
    input  logic [BP_PC_W-1:0]       fetch_pc,
    output logic                     lookup_grant,
    input  logic                     upd_valid,
    input  logic [BP_PC_W-1:0]       upd_pc,
    input  logic                     upd_br_en,
    output logic                     upd_ready,
    output logic [BP_PC_W-1:0]       pred_pc,
    output logic                     pred_ld,
    output logic                     pred_br_en,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    bp_upd_t        head_entry;
    bp_upd_t        new_entry;
    logic           full;
    logic           empty;
    logic           enq;
    logic           drain;
    logic [SW-1:0]  starve;

    assign new_entry = '{pc: upd_pc, br_en: upd_br_en};
    assign upd_ready = !full;
    assign enq       = upd_valid && upd_ready;

    bp_upd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .enq       (enq),
        .enq_data  (new_entry),
        .deq       (drain),
        .head_data (head_entry),
        .count     (q_count),
        .full      (full),
        .empty     (empty)
    );

    // Decide who owns the predictor port this cycle and steer its inputs accordingly.
    always_comb begin
        drain        = !empty && (!lookup_req || full || (starve == SW'(STARVE_LIMIT)));
        pred_ld      = 1'b0;
        pred_br_en   = 1'b0;
        pred_pc      = fetch_pc;
        lookup_grant = lookup_req;
        if (drain) begin
            pred_ld      = 1'b1;
            pred_br_en   = head_entry.br_en;
            pred_pc      = head_entry.pc;
            lookup_grant = 1'b0;
        end
    end

    // Count consecutive cycles where updates waited behind fetch, saturating at the limit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            starve <= '0;
        end else if (drain || empty) begin
            starve <= '0;
        end else if (starve != SW'(STARVE_LIMIT)) begin
            starve <= starve + 1'b1;
        end
    end

endmodule

// File: tb/tb_bp_update_arbiter.sv
// Self-checking bench for bp_update_arbiter: hand-computed vector table plus scoreboard-driven sequences.
import bp_pkg::*;

module tb_bp_update_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lookup_req = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic        lookup_grant;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_br_en = 1'b0;
    logic        upd_ready;
    logic [31:0] pred_pc;
    logic        pred_ld;
    logic        pred_br_en;
    logic [2:0]  q_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard of accepted updates in arrival order, plus the bench's own starve count.
    bp_upd_t sb[$];
    int      m_starve = 0;

    typedef struct {
        bit          rst;
        bit          lreq;
        logic [31:0] fpc;
        bit          uv;
        logic [31:0] upc;
        bit          ube;
        bit          chk;
        bit          e_grant;
        bit          e_ld;
        logic [31:0] e_pc;
        bit          e_br;
        bit          e_ready;
        int          e_count;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    bp_update_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .lookup_req   (lookup_req),
        .fetch_pc     (fetch_pc),
        .lookup_grant (lookup_grant),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_br_en    (upd_br_en),
        .upd_ready    (upd_ready),
        .pred_pc      (pred_pc),
        .pred_ld      (pred_ld),
        .pred_br_en   (pred_br_en),
        .q_count      (q_count)
    );

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
        end
    endtask

    // Compare DUT against the scoreboard for the current cycle, then advance the scoreboard.
    task automatic modelStep(input bit do_check);
        bit      exp_ready;
        bit      exp_drain;
        bit      enq;
        bp_upd_t hd;
        exp_ready = (sb.size() != DEPTH);
        exp_drain = (sb.size() != 0) && (!lookup_req || sb.size() == DEPTH || m_starve == LIMIT);
        hd = '0;
        if (sb.size() != 0) hd = sb[0];
        if (do_check) begin
            checkOutput("q_count",      32'(q_count),      32'(sb.size()));
            checkOutput("upd_ready",    32'(upd_ready),    32'(exp_ready));
            checkOutput("pred_ld",      32'(pred_ld),      32'(exp_drain));
            checkOutput("lookup_grant", 32'(lookup_grant), exp_drain ? 32'd0 : 32'(lookup_req));
            checkOutput("pred_pc",      pred_pc,           exp_drain ? hd.pc : fetch_pc);
            checkOutput("pred_br_en",   32'(pred_br_en),   exp_drain ? 32'(hd.br_en) : 32'd0);
        end
        if (!rst) begin
            sb.delete();
            m_starve = 0;
        end else begin
            enq = upd_valid && exp_ready;
            if (exp_drain || sb.size() == 0) m_starve = 0;
            else if (m_starve < LIMIT) m_starve++;
            if (exp_drain) void'(sb.pop_front());
            if (enq) sb.push_back('{pc: upd_pc, br_en: upd_br_en});
        end
    endtask

    // Drive one cycle's inputs after the falling edge and evaluate before the next rising edge.
    task automatic applyStimulus(input bit r, input bit lreq, input logic [31:0] fpc,
                                 input bit uv, input logic [31:0] upc, input bit ube,
                                 input bit do_check);
        @(negedge clk);
        rst        = r;
        lookup_req = lreq;
        fetch_pc   = fpc;
        upd_valid  = uv;
        upd_pc     = upc;
        upd_br_en  = ube;
        #1;
        modelStep(do_check);
    endtask

    initial begin
        bit accepted;
        bit seen_stale;

        // Reset with traffic present, then an in-order drain with fetch idle.
        vecs[0] = '{1'b0, 1'b1, 32'h0A0, 1'b1, 32'h999, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 0};
        vecs[1] = '{1'b1, 1'b1, 32'h0A4, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b0, 32'h0A4, 1'b0, 1'b1, 0};
        vecs[2] = '{1'b1, 1'b0, 32'h0B0, 1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0B0, 1'b0, 1'b1, 0};
        vecs[3] = '{1'b1, 1'b0, 32'h0B0, 1'b1, 32'h104, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 1};
        vecs[4] = '{1'b1, 1'b0, 32'h0B0, 1'b1, 32'h108, 1'b1, 1'b1, 1'b0, 1'b1, 32'h104, 1'b0, 1'b1, 1};
        vecs[5] = '{1'b1, 1'b0, 32'h0B0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b1, 32'h108, 1'b1, 1'b1, 1};
        vecs[6] = '{1'b1, 1'b0, 32'h0B0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0, 32'h0B0, 1'b0, 1'b1, 0};

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].lreq, vecs[i].fpc, vecs[i].uv,
                          vecs[i].upc, vecs[i].ube, 1'b0);
            if (vecs[i].chk) begin
                checkOutput("tbl_q_count",    32'(q_count),      32'(vecs[i].e_count));
                checkOutput("tbl_upd_ready",  32'(upd_ready),    32'(vecs[i].e_ready));
                checkOutput("tbl_pred_ld",    32'(pred_ld),      32'(vecs[i].e_ld));
                checkOutput("tbl_grant",      32'(lookup_grant), 32'(vecs[i].e_grant));
                checkOutput("tbl_pred_pc",    pred_pc,           vecs[i].e_pc);
                checkOutput("tbl_pred_br_en", 32'(pred_br_en),   32'(vecs[i].e_br));
            end
        end

        // Fetch hogs the port; queued updates must be forced through by the starve limit.
        applyStimulus(1'b1, 1'b1, 32'h200, 1'b1, 32'h100, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h204, 1'b1, 32'h104, 1'b0, 1'b1);
        for (int i = 0; i < 24; i++)
            applyStimulus(1'b1, 1'b1, 32'h208 + 32'(4 * i), 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("starve_queue_empty", 32'(q_count), 32'd0);

        // Fill to DEPTH under constant lookups; the fifth update is held until space frees.
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(1'b1, 1'b1, 32'h300, 1'b1, 32'h400 + 32'(4 * i), 1'(i), 1'b1);
        accepted = 1'b0;
        for (int i = 0; i < 10 && !accepted; i++) begin
            accepted = (sb.size() != DEPTH);
            applyStimulus(1'b1, 1'b1, 32'h304, 1'b1, 32'h410, 1'b1, 1'b1);
        end
        checkOutput("held_update_accepted", 32'(accepted), 32'd1);
        for (int i = 0; i < 12; i++)
            applyStimulus(1'b1, 1'b0, 32'h308, 1'b0, 32'h0, 1'b0, 1'b1);

        // Steady state at occupancy 2: one enqueue and one drain every cycle.
        applyStimulus(1'b1, 1'b1, 32'h500, 1'b1, 32'h500, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h504, 1'b1, 32'h504, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h50C, 1'b1, 32'h508 + 32'(4 * i), 1'(i + 1), 1'b1);
            checkOutput("steady_q_count", 32'(q_count), 32'd2);
        end
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 1'b0, 32'h520, 1'b0, 32'h0, 1'b0, 1'b1);

        // Reset with three updates pending; none of them may ever reach the predictor.
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 1'b1, 32'h700, 1'b1, 32'h600 + 32'(4 * i), 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h704, 1'b0, 32'h0, 1'b0, 1'b1);
        seen_stale = 1'b0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h708, 1'b0, 32'h0, 1'b0, 1'b1);
            if (pred_ld && (pred_pc == 32'h600 || pred_pc == 32'h604 || pred_pc == 32'h608))
                seen_stale = 1'b1;
        end
        checkOutput("no_stale_drain", 32'(seen_stale), 32'd0);

        // Random traffic against the scoreboard, with occasional resets.
        for (int i = 0; i < 300; i++)
            applyStimulus(($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)),
                          $urandom, 1'($urandom_range(0, 1)), $urandom,
                          1'($urandom_range(0, 1)), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
